// File: rtl/load_store_unit_pkg.sv
// Shared CPU profile for the load/store unit: widths, access sizes, RV32I funct3 codes and FSM states.
// Also provides the funct3 legality check used when a request is accepted.
package load_store_unit_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int ADDR_SHIFT_DEF = 2;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SECOND = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

    // Stores have no unsigned variants, so funct3[2] is only legal on loads.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_store);
        case (f3)
            F3_LB, F3_LH, F3_LW: return 1'b1;
            F3_LBU, F3_LHU:      return !is_store;
            default:             return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane alignment (the lsu_align block): byte strobes and shifted store data for one word half,
// plus extract/extend of load data from a 64-bit little-endian window.
module load_store_unit_align
    import load_store_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic              sel_hi_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [2*XLEN-1:0] rdata_i,
    output logic              misaligned_o,
    output logic [3:0]        strb_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic [XLEN-1:0]   rdata_o
);

    mem_size_e         size;
    logic [3:0]        nbytes;
    logic [7:0]        strb8;
    logic [2*XLEN-1:0] wdata64;
    logic [XLEN-1:0]   shifted;
    logic              sext;

    // Everything is computed on a two-word view; sel_hi_i picks which word the caller is issuing.
    always_comb begin
        size         = mem_size_e'(funct3_i[1:0]);
        nbytes       = 4'd1 << funct3_i[1:0];
        misaligned_o = ({2'b00, offset_i} + nbytes) > 4'd4;
        strb8        = ((8'd1 << nbytes) - 8'd1) << offset_i;
        wdata64      = {{XLEN{1'b0}}, wdata_i} << {offset_i, 3'b000};
        strb_o       = sel_hi_i ? strb8[7:4] : strb8[3:0];
        wdata_o      = sel_hi_i ? wdata64[2*XLEN-1:XLEN] : wdata64[XLEN-1:0];
        shifted      = XLEN'(rdata_i >> {offset_i, 3'b000});
        sext         = ~funct3_i[2];
        case (size)
            BYTE:    rdata_o = {{(XLEN-8){sext & shifted[7]}}, shifted[7:0]};
            HALF:    rdata_o = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
            default: rdata_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the CPU memory stage and the DMEM port (one request in flight).
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned accesses into two word accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int ADDR_SHIFT = ADDR_SHIFT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_ren,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            dmem_wen,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic SplitEn = 1'b1;
`else
    localparam logic SplitEn = 1'b0;
`endif

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic            err_q, err_d;
    logic            split_q, split_d;

    logic              useReq;
    logic              selHi;
    logic              reqErr;
    logic [XLEN-1:0]   wordAddr;
    logic [2:0]        alignF3;
    logic [1:0]        alignOff;
    logic [XLEN-1:0]   alignWdataIn;
    logic [2*XLEN-1:0] alignRdataIn;
    logic              misaligned;
    logic [3:0]        alignStrb;
    logic [XLEN-1:0]   alignWdata;
    logic [XLEN-1:0]   alignRdata;

    // In IDLE the aligner sees the live request; afterwards it works from the captured copy.
    assign useReq       = (state_q == IDLE);
    assign selHi        = (state_q == SECOND);
    assign alignF3      = useReq ? req_funct3 : funct3_q;
    assign alignOff     = useReq ? req_addr[1:0] : addr_q[1:0];
    assign alignWdataIn = useReq ? req_wdata : wdata_q;
    assign alignRdataIn = split_q ? {dmem_rdata, lo_q} : {{XLEN{1'b0}}, dmem_rdata};
    assign wordAddr     = ((useReq ? req_addr : addr_q) >> ADDR_SHIFT) << ADDR_SHIFT;

    load_store_unit_align #(.XLEN(XLEN)) u_align (
        .funct3_i    (alignF3),
        .offset_i    (alignOff),
        .sel_hi_i    (selHi),
        .wdata_i     (alignWdataIn),
        .rdata_i     (alignRdataIn),
        .misaligned_o(misaligned),
        .strb_o      (alignStrb),
        .wdata_o     (alignWdata),
        .rdata_o     (alignRdata)
    );

    // Next-state and outputs; reset masks the handshake and memory strobes at the very end.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lo_d       = lo_q;
        err_d      = err_q;
        split_d    = split_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        dmem_addr  = '0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_wstrb = '0;
        dmem_wdata = '0;
        reqErr     = !funct3_legal(req_funct3, req_we) || (misaligned && !SplitEn);

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !rst) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    err_d    = reqErr;
                    split_d  = misaligned && !reqErr;
                    if (!reqErr) begin
                        dmem_addr  = wordAddr;
                        dmem_ren   = !req_we;
                        dmem_wen   = req_we;
                        dmem_wstrb = req_we ? alignStrb : 4'b0000;
                        dmem_wdata = req_we ? alignWdata : '0;
                    end
                    state_d = (misaligned && !reqErr) ? SECOND : RESP;
                end
            end
            SECOND: begin
                dmem_addr  = wordAddr + (XLEN'(1) << ADDR_SHIFT);
                dmem_ren   = !we_q;
                dmem_wen   = we_q;
                dmem_wstrb = we_q ? alignStrb : 4'b0000;
                dmem_wdata = we_q ? alignWdata : '0;
                if (!we_q) begin
                    lo_d = dmem_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (we_q || err_q) ? '0 : alignRdata;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rst) begin
            req_ready  = 1'b0;
            dmem_ren   = 1'b0;
            dmem_wen   = 1'b0;
            dmem_wstrb = 4'b0000;
            resp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            err_q    <= 1'b0;
            split_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            err_q    <= err_d;
            split_q  <= split_d;
        end
    end

endmodule
